// File: rtl/shift_tap_pkg.sv
// Shared types and helpers for the 3x3 shift-tap sequencing controller.
package shift_tap_pkg;

    // Controller states
    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        ACTIVE,
        HBLANK,
        FLUSH
    } state_t;

    // Number of physical line buffers that lb_wsel rotates through
    localparam int WSEL_WRAP = 3;

    // Bits needed to hold a counter that runs 0..n inclusive
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers one sync input (normalised to active-high via POL) and
// produces single-cycle rise/fall pulses from the registered copy.
module sync_edge_det #(
    parameter bit POL = 1'b1
) (
    input  logic clock,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic q_r;
    logic q_rr;

    // Input register plus one cycle of history for edge detection
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            q_r  <= 1'b0;
            q_rr <= 1'b0;
        end else begin
            q_r  <= (d == POL);
            q_rr <= q_r;
        end
    end

    assign rise = q_r & ~q_rr;
    assign fall = ~q_r & q_rr;

endmodule

// File: rtl/shift_tap_ctrl.sv
// Sequencing controller for the 3x3 shift-tap datapath: line-buffer write
// control, rotating buffer select, window-centre strobe and a bottom-row
// flush line. Optional border flags are built when SHIFT_TAP_BORDER_EN is
// defined; otherwise the edge_* outputs are tied low.
module shift_tap_ctrl
    import shift_tap_pkg::*;
#(
    parameter int VIDEO_WIDTH  = 1920,
    parameter int VIDEO_HEIGHT = 1080,
    parameter int AW           = cnt_width(VIDEO_WIDTH),
    parameter int RW           = cnt_width(VIDEO_HEIGHT),
    parameter bit VS_ACTIVE    = 1'b1
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          invs,
    input  logic          inde,
    output logic          lb_we,
    output logic          lb_re,
    output logic [AW-1:0] lb_addr,
    output logic [1:0]    lb_wsel,
    output logic          win_valid,
    output logic [AW-1:0] win_col,
    output logic [RW-1:0] win_row,
    output logic          edge_top,
    output logic          edge_bot,
    output logic          edge_left,
    output logic          edge_right,
    output logic          err_len,
    output logic          err_frame,
    output logic          busy
);

    localparam logic [AW-1:0] W_C  = AW'(VIDEO_WIDTH);
    localparam logic [RW-1:0] H_C  = RW'(VIDEO_HEIGHT);
    localparam logic [1:0]    WSEL_LAST = 2'(WSEL_WRAP - 1);

    state_t        state;
    logic [AW-1:0] col;        // next column in a line, flush address in FLUSH
    logic [RW-1:0] row;        // lines completed this frame, saturates at H
    logic          flushed;    // bottom row already drained this frame
    logic          vs_clr;     // clear the vsync-time err_frame pulse

    logic          vs_rise;
    logic          vs_fall_unused;
    logic          de_rise;
    logic          de_fall;

    logic          pix;
    logic [AW-1:0] pix_col;
    logic          wv_d;
    logic [AW-1:0] wc_d;
    logic [RW-1:0] wr_d;

    sync_edge_det #(.POL(VS_ACTIVE)) u_vs (
        .clock (clock),
        .rst   (rst),
        .d     (invs),
        .rise  (vs_rise),
        .fall  (vs_fall_unused)
    );

    sync_edge_det #(.POL(1'b1)) u_de (
        .clock (clock),
        .rst   (rst),
        .d     (inde),
        .rise  (de_rise),
        .fall  (de_fall)
    );

    // A pixel is presented this cycle: either mid-line, or the first pixel
    // of a line (which may also abort a flush). Line start always uses col 0.
    always_comb begin
        pix = 1'b0;
        if (!vs_rise) begin
            if (state == ACTIVE)
                pix = !de_fall;
            else if (state == WAIT_FRAME || state == HBLANK || state == FLUSH)
                pix = de_rise;
        end
        pix_col = (state == ACTIVE) ? col : '0;
    end

    // Next window-centre strobe: in-line centres lag the written pixel by
    // one row and column, the end-of-line strobe fills column W-1, and the
    // flush line supplies the bottom row.
    always_comb begin
        wv_d = 1'b0;
        wc_d = '0;
        wr_d = '0;
        if (pix) begin
            if (row != '0 && row < H_C && pix_col != '0 && pix_col < W_C) begin
                wv_d = 1'b1;
                wc_d = pix_col - AW'(1);
                wr_d = row - RW'(1);
            end
        end else if (!vs_rise && state == ACTIVE && de_fall) begin
            if (row != '0 && row < H_C) begin
                wv_d = 1'b1;
                wc_d = W_C - AW'(1);
                wr_d = row - RW'(1);
            end
        end else if (!vs_rise && state == FLUSH && col != '0) begin
            wv_d = 1'b1;
            wc_d = col - AW'(1);
            wr_d = H_C - RW'(1);
        end
    end

    // Control FSM with registered line-buffer, window and status outputs
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            flushed   <= 1'b0;
            vs_clr    <= 1'b0;
            lb_we     <= 1'b0;
            lb_re     <= 1'b0;
            lb_addr   <= '0;
            lb_wsel   <= '0;
            win_valid <= 1'b0;
            win_col   <= '0;
            win_row   <= '0;
            err_len   <= 1'b0;
            err_frame <= 1'b0;
            busy      <= 1'b0;
        end else begin
            lb_we     <= 1'b0;
            lb_re     <= 1'b0;
            lb_addr   <= '0;
            win_valid <= wv_d;
            win_col   <= wc_d;
            win_row   <= wr_d;

            if (vs_clr) begin
                err_frame <= 1'b0;
                vs_clr    <= 1'b0;
            end

            if (vs_rise) begin
                // Frame start aborts whatever was in flight. A frame that ended
                // short shows err_frame for one cycle before it clears.
                state   <= WAIT_FRAME;
                busy    <= 1'b0;
                row     <= '0;
                col     <= '0;
                lb_wsel <= '0;
                err_len <= 1'b0;
                flushed <= 1'b0;
                if (state != IDLE && row != H_C && !flushed) begin
                    err_frame <= 1'b1;
                    vs_clr    <= 1'b1;
                end else begin
                    err_frame <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: ;
                    WAIT_FRAME, HBLANK: begin
                        if (pix) begin
                            state <= ACTIVE;
                            busy  <= 1'b1;
                        end else if (state == HBLANK && row == H_C) begin
                            col <= '0;
                            if (flushed) begin
                                state <= WAIT_FRAME;
                                busy  <= 1'b0;
                            end else begin
                                state <= FLUSH;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    ACTIVE: begin
                        if (de_fall) begin
                            if (col != W_C)
                                err_len <= 1'b1;
                            col     <= '0;
                            lb_wsel <= (lb_wsel == WSEL_LAST) ? 2'd0 : lb_wsel + 2'd1;
                            if (row != H_C)
                                row <= row + RW'(1);
                            state   <= HBLANK;
                        end
                    end
                    FLUSH: begin
                        if (pix) begin
                            // de arrived before the drain finished
                            err_frame <= 1'b1;
                            state     <= ACTIVE;
                        end else begin
                            lb_re   <= 1'b1;
                            lb_addr <= col;
                            if (col == W_C) begin
                                col     <= '0;
                                flushed <= 1'b1;
                                state   <= WAIT_FRAME;
                                busy    <= 1'b0;
                            end else begin
                                col <= col + AW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase

                if (pix) begin
                    lb_addr <= pix_col;
                    if (pix_col == W_C)
                        err_len <= 1'b1;
                    else
                        col <= pix_col + AW'(1);
                    if (row == H_C)
                        err_frame <= 1'b1;
                    else if (pix_col != W_C) begin
                        lb_we <= 1'b1;
                        lb_re <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef SHIFT_TAP_BORDER_EN
    // Border flags for the centre being presented, qualified by the strobe
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            edge_top   <= 1'b0;
            edge_bot   <= 1'b0;
            edge_left  <= 1'b0;
            edge_right <= 1'b0;
        end else begin
            edge_top   <= wv_d && (wr_d == '0);
            edge_bot   <= wv_d && (wr_d == H_C - RW'(1));
            edge_left  <= wv_d && (wc_d == '0);
            edge_right <= wv_d && (wc_d == W_C - AW'(1));
        end
    end
`else
    assign edge_top   = 1'b0;
    assign edge_bot   = 1'b0;
    assign edge_left  = 1'b0;
    assign edge_right = 1'b0;
`endif

endmodule

// File: tb/tb_shift_tap_ctrl.sv
// Directed bench for shift_tap_ctrl at W=8, H=4.
module tb_shift_tap_ctrl;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AW = 4;
    localparam int RW = 3;

    logic          clock = 1'b0;
    logic          rst   = 1'b1;
    logic          invs  = 1'b0;
    logic          inde  = 1'b0;
    logic          lb_we, lb_re, win_valid;
    logic [AW-1:0] lb_addr, win_col;
    logic [1:0]    lb_wsel;
    logic [RW-1:0] win_row;
    logic          edge_top, edge_bot, edge_left, edge_right;
    logic          err_len, err_frame, busy;

    int chk  = 0;
    int fail = 0;

    int we_addr[$];
    int we_wsel[$];
    int fl_addr[$];
    int win_r[$];
    int win_c[$];
    int n_top, n_bot, n_left, n_right, n_stray, n_ef;
    logic [3:0] corner;

    always #5 clock = ~clock;

    shift_tap_ctrl #(
        .VIDEO_WIDTH (W),
        .VIDEO_HEIGHT(H),
        .AW          (AW),
        .RW          (RW),
        .VS_ACTIVE   (1'b1)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .invs      (invs),
        .inde      (inde),
        .lb_we     (lb_we),
        .lb_re     (lb_re),
        .lb_addr   (lb_addr),
        .lb_wsel   (lb_wsel),
        .win_valid (win_valid),
        .win_col   (win_col),
        .win_row   (win_row),
        .edge_top  (edge_top),
        .edge_bot  (edge_bot),
        .edge_left (edge_left),
        .edge_right(edge_right),
        .err_len   (err_len),
        .err_frame (err_frame),
        .busy      (busy)
    );

    // Record output activity on the falling edge
    always @(negedge clock) begin
        if (lb_we) begin
            we_addr.push_back(int'(lb_addr));
            we_wsel.push_back(int'(lb_wsel));
        end
        if (lb_re && !lb_we)
            fl_addr.push_back(int'(lb_addr));
        if (win_valid) begin
            win_r.push_back(int'(win_row));
            win_c.push_back(int'(win_col));
            n_top   += int'(edge_top);
            n_bot   += int'(edge_bot);
            n_left  += int'(edge_left);
            n_right += int'(edge_right);
            if (win_row == 0 && win_col == 0)
                corner = {edge_top, edge_left, edge_bot, edge_right};
        end else if (edge_top || edge_bot || edge_left || edge_right) begin
            n_stray++;
        end
        if (err_frame)
            n_ef++;
    end

    function automatic logic [31:0] outs();
        return 32'({lb_we, lb_re, lb_addr, lb_wsel, win_valid, win_col, win_row,
                    edge_top, edge_bot, edge_left, edge_right, err_len, err_frame, busy});
    endfunction

    task automatic clr_mon();
        @(posedge clock);
        #1;
        we_addr.delete(); we_wsel.delete(); fl_addr.delete();
        win_r.delete(); win_c.delete();
        n_top = 0; n_bot = 0; n_left = 0; n_right = 0; n_stray = 0; n_ef = 0;
        corner = 4'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic line(input int n);
        repeat (n) begin
            @(negedge clock);
            inde = 1'b1;
        end
        @(negedge clock);
        inde = 1'b0;
    endtask

    task automatic vs_pulse();
        @(negedge clock);
        invs = 1'b1;
        repeat (2) @(negedge clock);
        invs = 1'b0;
    endtask

    // vsync, then n full-width lines, then enough blanking for the flush
    task automatic run_frame(input int n);
        vs_pulse();
        gap(4);
        clr_mon();
        repeat (n) begin
            line(W);
            gap(4);
        end
        gap(12);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        chk++;
        if (outs() !== 32'd0) begin
            fail++; $display("FAIL reset_outputs: got %h want 0", outs());
        end
        rst = 1'b0;
        gap(3);
        chk++;
        if (outs() !== 32'd0) begin
            fail++; $display("FAIL idle_outputs: got %h want 0", outs());
        end
        clr_mon();
        line(W);
        gap(4);
        chk++;
        if (we_addr.size() != 0 || busy !== 1'b0) begin
            fail++; $display("FAIL idle_ignores_de: we=%0d busy=%b want 0/0", we_addr.size(), busy);
        end
    endtask

    task automatic test_clean_frame();
        int bad_a = 0;
        int bad_s = 0;
        int bad_w = 0;
        int bad_f = 0;
        run_frame(H);
        chk++;
        if (we_addr.size() != 32) begin
            fail++; $display("FAIL clean_we_count: got %0d want 32", we_addr.size());
        end
        for (int i = 0; i < we_addr.size(); i++) begin
            if (we_addr[i] != i % W) bad_a++;
            if (we_wsel[i] != (i / W) % 3) bad_s++;
        end
        chk++;
        if (bad_a != 0) begin
            fail++; $display("FAIL clean_we_addr: %0d wrong addresses want 0", bad_a);
        end
        chk++;
        if (bad_s != 0) begin
            fail++; $display("FAIL clean_wsel_seq: %0d wrong selects want 0", bad_s);
        end
        chk++;
        if (win_r.size() != 32) begin
            fail++; $display("FAIL clean_win_count: got %0d want 32", win_r.size());
        end
        for (int i = 0; i < win_r.size(); i++)
            if (win_r[i] != i / W || win_c[i] != i % W) bad_w++;
        chk++;
        if (bad_w != 0) begin
            fail++; $display("FAIL clean_win_order: %0d wrong centres want 0", bad_w);
        end
        chk++;
        if (fl_addr.size() != W + 1) begin
            fail++; $display("FAIL clean_flush_len: got %0d want %0d", fl_addr.size(), W + 1);
        end
        for (int i = 0; i < fl_addr.size(); i++)
            if (fl_addr[i] != i) bad_f++;
        chk++;
        if (bad_f != 0) begin
            fail++; $display("FAIL clean_flush_addr: %0d wrong addresses want 0", bad_f);
        end
        chk++;
        if (err_len !== 1'b0 || n_ef != 0) begin
            fail++; $display("FAIL clean_no_err: err_len=%b err_frame_cycles=%0d want 0/0", err_len, n_ef);
        end
        chk++;
        if (busy !== 1'b0) begin
            fail++; $display("FAIL clean_busy_end: got %b want 0", busy);
        end
    endtask

    task automatic test_border();
        int e_tb;
        int e_lr;
        logic [3:0] e_corner;
`ifdef SHIFT_TAP_BORDER_EN
        e_tb = W; e_lr = H; e_corner = 4'b1100;
`else
        e_tb = 0; e_lr = 0; e_corner = 4'b0000;
`endif
        run_frame(H);
        chk++;
        if (n_top != e_tb) begin
            fail++; $display("FAIL border_top: got %0d want %0d", n_top, e_tb);
        end
        chk++;
        if (n_bot != e_tb) begin
            fail++; $display("FAIL border_bot: got %0d want %0d", n_bot, e_tb);
        end
        chk++;
        if (n_left != e_lr) begin
            fail++; $display("FAIL border_left: got %0d want %0d", n_left, e_lr);
        end
        chk++;
        if (n_right != e_lr) begin
            fail++; $display("FAIL border_right: got %0d want %0d", n_right, e_lr);
        end
        chk++;
        if (corner !== e_corner) begin
            fail++; $display("FAIL border_corner: got %b want %b", corner, e_corner);
        end
        chk++;
        if (n_stray != 0) begin
            fail++; $display("FAIL border_unqualified: got %0d want 0", n_stray);
        end
    endtask

    task automatic test_short_line();
        int bad = 0;
        vs_pulse();
        gap(4);
        clr_mon();
        line(W); gap(4);
        line(W); gap(4);
        chk++;
        if (err_len !== 1'b0) begin
            fail++; $display("FAIL short_err_before: got %b want 0", err_len);
        end
        line(6); gap(4);
        chk++;
        if (err_len !== 1'b1) begin
            fail++; $display("FAIL short_err_set: got %b want 1", err_len);
        end
        line(W); gap(4);
        gap(12);
        chk++;
        if (we_addr.size() != 30 || win_r.size() != 30) begin
            fail++; $display("FAIL short_counts: we=%0d win=%0d want 30/30", we_addr.size(), win_r.size());
        end
        for (int i = 0; i < we_addr.size(); i++) begin
            if (i < 16 && we_addr[i] != i % W) bad++;
            if (i >= 16 && i < 22 && we_addr[i] != i - 16) bad++;
            if (i >= 22 && we_addr[i] != i - 22) bad++;
        end
        chk++;
        if (bad != 0) begin
            fail++; $display("FAIL short_addr: %0d wrong addresses want 0", bad);
        end
        chk++;
        if (err_len !== 1'b1 || n_ef != 0) begin
            fail++; $display("FAIL short_err_hold: err_len=%b err_frame_cycles=%0d want 1/0", err_len, n_ef);
        end
        vs_pulse();
        gap(4);
        chk++;
        if (err_len !== 1'b0) begin
            fail++; $display("FAIL short_err_clear: got %b want 0", err_len);
        end
    endtask

    task automatic test_long_frame();
        run_frame(H);
        chk++;
        if (err_frame !== 1'b0 || n_ef != 0) begin
            fail++; $display("FAIL long_err_before: got %b want 0", err_frame);
        end
        line(W);
        gap(4);
        chk++;
        if (err_frame !== 1'b1) begin
            fail++; $display("FAIL long_err_frame: got %b want 1", err_frame);
        end
        chk++;
        if (we_addr.size() != 32) begin
            fail++; $display("FAIL long_we_count: got %0d want 32", we_addr.size());
        end
    endtask

    task automatic test_short_frame();
        vs_pulse();
        gap(4);
        repeat (3) begin
            line(W);
            gap(4);
        end
        chk++;
        if (err_frame !== 1'b0) begin
            fail++; $display("FAIL sframe_before: got %b want 0", err_frame);
        end
        clr_mon();
        vs_pulse();
        gap(4);
        chk++;
        if (n_ef != 1) begin
            fail++; $display("FAIL sframe_pulse: got %0d cycles want 1", n_ef);
        end
        chk++;
        if (err_frame !== 1'b0) begin
            fail++; $display("FAIL sframe_cleared: got %b want 0", err_frame);
        end
    endtask

    task automatic test_flush_abort();
        vs_pulse();
        gap(4);
        clr_mon();
        repeat (H - 1) begin
            line(W);
            gap(4);
        end
        line(W);
        gap(4);
        chk++;
        if (lb_re !== 1'b1 || lb_we !== 1'b0 || lb_addr !== 4'd0) begin
            fail++; $display("FAIL abort_flush_start: re=%b we=%b addr=%0d want 1/0/0", lb_re, lb_we, lb_addr);
        end
        @(negedge clock);
        inde = 1'b1;
        repeat (2) @(negedge clock);
        chk++;
        if (lb_addr !== 4'd0 || lb_we !== 1'b0 || lb_re !== 1'b0) begin
            fail++; $display("FAIL abort_restart: addr=%0d we=%b re=%b want 0/0/0", lb_addr, lb_we, lb_re);
        end
        chk++;
        if (err_frame !== 1'b1 || busy !== 1'b1) begin
            fail++; $display("FAIL abort_flags: err_frame=%b busy=%b want 1/1", err_frame, busy);
        end
        @(negedge clock);
        chk++;
        if (lb_addr !== 4'd1) begin
            fail++; $display("FAIL abort_active: addr=%0d want 1", lb_addr);
        end
        repeat (4) @(negedge clock);
        @(negedge clock);
        inde = 1'b0;
        gap(4);
        chk++;
        if (fl_addr.size() != 3 || we_addr.size() != 32) begin
            fail++; $display("FAIL abort_counts: flush=%0d we=%0d want 3/32", fl_addr.size(), we_addr.size());
        end
    endtask

    task automatic test_reset_midline();
        int bad = 0;
        vs_pulse();
        gap(4);
        repeat (3) begin
            @(negedge clock);
            inde = 1'b1;
        end
        @(negedge clock);
        rst = 1'b1;
        #1;
        chk++;
        if (outs() !== 32'd0) begin
            fail++; $display("FAIL midrst_async: got %h want 0", outs());
        end
        @(posedge clock);
        #1;
        chk++;
        if (outs() !== 32'd0) begin
            fail++; $display("FAIL midrst_edge: got %h want 0", outs());
        end
        clr_mon();
        @(negedge clock);
        rst = 1'b0;
        repeat (2) @(negedge clock);
        @(negedge clock);
        inde = 1'b0;
        gap(6);
        chk++;
        if (we_addr.size() != 0 || busy !== 1'b0) begin
            fail++; $display("FAIL midrst_quiet: we=%0d busy=%b want 0/0", we_addr.size(), busy);
        end
        vs_pulse();
        gap(4);
        line(W);
        gap(4);
        for (int i = 0; i < we_addr.size(); i++)
            if (we_addr[i] != i) bad++;
        chk++;
        if (we_addr.size() != W || bad != 0) begin
            fail++; $display("FAIL midrst_resume: we=%0d bad=%0d want %0d/0", we_addr.size(), bad, W);
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_border();
        test_short_line();
        test_long_frame();
        test_short_frame();
        test_flush_abort();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", chk, fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, checks=%0d", chk);
        $fatal(1, "watchdog expired");
    end

endmodule
